// File: rtl/aemb2_mul_wb.sv
// Multiplier writeback: tags in-flight MULs, merges their results with ALU writes
// onto the single register-file port, and flags hazards. Option: AEMB_MUL_WB_BYPASS_EN.
module aemb2_mul_wb #(
   parameter int AEMB_MUL = 1
) (
   input  logic        gclk,
   input  logic        grst,
   input  logic        dena,
   input  logic        gpha,
   input  logic        mul_of,
   input  logic [4:0]  rd_of,
   input  logic [4:0]  ra_of,
   input  logic [4:0]  rb_of,
   input  logic [31:0] mul_mx,
   input  logic        alu_we,
   input  logic [5:0]  alu_wa,
   input  logic [31:0] alu_wd,
   output logic        rf_we,
   output logic [5:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        hzd,
   output logic        stall,
   output logic        fwd_a,
   output logic        fwd_b
);

   localparam bit MUL_EN = (AEMB_MUL != 0);

   logic        v0_q, v0_d, v1_q, v1_d;
   logic [5:0]  tag0_q, tag0_d, tag1_q, tag1_d;
   logic        rf_we_q, rf_we_d;
   logic [5:0]  rf_wa_q, rf_wa_d;
   logic [31:0] rf_wd_q, rf_wd_d;
   logic        hold_v_q, hold_v_d;
   logic [5:0]  hold_wa_q, hold_wa_d;
   logic [31:0] hold_wd_q, hold_wd_d;

   logic        mul_wr, alu_ok, stall_c;
   logic        m0_a, m0_b, m1_a, m1_b;
   logic        hzd_c, fwd_a_c, fwd_b_c;

   always_comb begin
      mul_wr  = v1_q & (tag1_q[4:0] != 5'd0);
      alu_ok  = alu_we & (alu_wa[4:0] != 5'd0);
      stall_c = mul_wr & alu_ok & hold_v_q;
   end

   // A stall cycle still retires the MUL; the ALU entry is simply not taken,
   // so the controller re-presents it until stall drops.
   always_comb begin
      v0_d      = v0_q;
      tag0_d    = tag0_q;
      v1_d      = v1_q;
      tag1_d    = tag1_q;
      rf_we_d   = 1'b0;
      rf_wa_d   = rf_wa_q;
      rf_wd_d   = rf_wd_q;
      hold_v_d  = hold_v_q;
      hold_wa_d = hold_wa_q;
      hold_wd_d = hold_wd_q;
      if (dena) begin
         v0_d   = mul_of & MUL_EN;
         tag0_d = {gpha, rd_of};
         v1_d   = v0_q;
         tag1_d = tag0_q;
         if (mul_wr) begin
            rf_we_d = 1'b1;
            rf_wa_d = tag1_q;
            rf_wd_d = mul_mx;
            if (alu_ok && !hold_v_q) begin
               hold_v_d  = 1'b1;
               hold_wa_d = alu_wa;
               hold_wd_d = alu_wd;
            end
         end else if (hold_v_q) begin
            rf_we_d   = 1'b1;
            rf_wa_d   = hold_wa_q;
            rf_wd_d   = hold_wd_q;
            hold_v_d  = alu_ok;
            hold_wa_d = alu_wa;
            hold_wd_d = alu_wd;
         end else if (alu_ok) begin
            rf_we_d = 1'b1;
            rf_wa_d = alu_wa;
            rf_wd_d = alu_wd;
         end
      end
   end

   always_ff @(posedge gclk) begin
      if (grst) begin
         v0_q      <= 1'b0;
         tag0_q    <= 6'd0;
         v1_q      <= 1'b0;
         tag1_q    <= 6'd0;
         rf_we_q   <= 1'b0;
         rf_wa_q   <= 6'd0;
         rf_wd_q   <= 32'd0;
         hold_v_q  <= 1'b0;
         hold_wa_q <= 6'd0;
         hold_wd_q <= 32'd0;
      end else begin
         v0_q      <= v0_d;
         tag0_q    <= tag0_d;
         v1_q      <= v1_d;
         tag1_q    <= tag1_d;
         rf_we_q   <= rf_we_d;
         rf_wa_q   <= rf_wa_d;
         rf_wd_q   <= rf_wd_d;
         hold_v_q  <= hold_v_d;
         hold_wa_q <= hold_wa_d;
         hold_wd_q <= hold_wd_d;
      end
   end

   // A MUL to r0 keeps its slot but can never create a dependency.
   always_comb begin
      m0_a = v0_q & (tag0_q[5] == gpha) & (tag0_q[4:0] != 5'd0) & (tag0_q[4:0] == ra_of);
      m0_b = v0_q & (tag0_q[5] == gpha) & (tag0_q[4:0] != 5'd0) & (tag0_q[4:0] == rb_of);
      m1_a = v1_q & (tag1_q[5] == gpha) & (tag1_q[4:0] != 5'd0) & (tag1_q[4:0] == ra_of);
      m1_b = v1_q & (tag1_q[5] == gpha) & (tag1_q[4:0] != 5'd0) & (tag1_q[4:0] == rb_of);
`ifdef AEMB_MUL_WB_BYPASS_EN
      hzd_c   = m0_a | m0_b;
      fwd_a_c = m1_a;
      fwd_b_c = m1_b;
`else
      hzd_c   = m0_a | m0_b | m1_a | m1_b;
      fwd_a_c = 1'b0;
      fwd_b_c = 1'b0;
`endif
   end

   assign rf_we = rf_we_q;
   assign rf_wa = rf_wa_q;
   assign rf_wd = rf_wd_q;
   assign hzd   = hzd_c & ~grst;
   assign stall = stall_c & ~grst;
   assign fwd_a = fwd_a_c & ~grst;
   assign fwd_b = fwd_b_c & ~grst;

endmodule
